// File: rtl/cw_pkg.sv
// rtl/cw_pkg.sv - control-word bit indices, flag indices and memory FSM states
package cw_pkg;

  localparam int CW_MAR2MEM  = 0;
  localparam int CW_PC2MBR   = 1;
  localparam int CW_PC2MAR   = 2;
  localparam int CW_MBR2PC   = 3;
  localparam int CW_MBR2IR   = 4;
  localparam int CW_MEM2MBR  = 5;
  localparam int CW_MBR2BR   = 6;
  localparam int CW_ACC2ALU  = 7;
  localparam int CW_MBR2MAR  = 8;
  localparam int CW_RSVD     = 9;
  localparam int CW_MBR2ACC  = 10;
  localparam int CW_ACC2MBR  = 11;
  localparam int CW_MBR2MEM  = 12;
  localparam int CW_IR2CU    = 13;
  localparam int CW_BR2ALU   = 14;
  localparam int CW_MR2MBR   = 15;
  localparam int CW_MPY2MR   = 16;
  localparam int CW_SEQ_LSB  = 17;
  localparam int CW_SEQ_MSB  = 19;
  localparam int CW_PC_PLUS1 = 20;
  localparam int CW_ACC_CLR  = 21;
  localparam int CW_ADD      = 22;
  localparam int CW_SUB      = 23;
  localparam int CW_AND      = 24;
  localparam int CW_OR       = 25;
  localparam int CW_NOT      = 26;
  localparam int CW_LSL      = 27;
  localparam int CW_LSR      = 28;
  localparam int CW_MPY      = 29;
  localparam int CW_ASL      = 30;
  localparam int CW_ASR      = 31;

  // ALU op vector is cw[CW_ADD +: ALU_OPS]; indices below are relative to it
  localparam int ALU_OPS = 10;
  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_AND = 2;
  localparam int ALU_OR  = 3;
  localparam int ALU_NOT = 4;
  localparam int ALU_LSL = 5;
  localparam int ALU_LSR = 6;
  localparam int ALU_MPY = 7;
  localparam int ALU_ASL = 8;
  localparam int ALU_ASR = 9;

  localparam int FLG_NEG   = 0;
  localparam int FLG_ZERO  = 1;
  localparam int FLG_CARRY = 2;
  localparam int FLG_OVF   = 3;
  localparam int FLG_ERR   = 4;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_RD   = 2'd1,
    MEM_WR   = 2'd2
  } mem_state_e;

endpackage

// File: rtl/cw_datapath_if.sv
// rtl/cw_datapath_if.sv - memory request/acknowledge bus between datapath and memory
interface cw_datapath_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/cw_alu.sv
// rtl/cw_alu.sv - combinational ALU and signed multiplier on ACC (a) and BR (b)
module cw_alu
  import cw_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [ALU_OPS-1:0]  op,
  output logic [DATA_W-1:0]   result,
  output logic                carry,
  output logic                overflow,
  output logic [2*DATA_W-1:0] product
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  logic [SH_W-1:0]     sh;
  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     diff;
  logic [DATA_W:0]     wide;
  logic [2*DATA_W-1:0] a_ext;
  logic [2*DATA_W-1:0] b_ext;

  assign sh    = b[SH_W-1:0];
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  // bit DATA_W of the shifted value is the last bit pushed out on the left
  assign wide  = {1'b0, a} << sh;
  assign a_ext = {{DATA_W{a[MSB]}}, a};
  assign b_ext = {{DATA_W{b[MSB]}}, b};
  assign product = a_ext * b_ext;

  always_comb begin
    result   = a;
    carry    = 1'b0;
    overflow = 1'b0;
    if (op[ALU_ADD]) begin
      result   = sum[MSB:0];
      carry    = sum[DATA_W];
      overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
    end else if (op[ALU_SUB]) begin
      result   = diff[MSB:0];
      carry    = ~diff[DATA_W];
      overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
    end else if (op[ALU_AND]) begin
      result = a & b;
    end else if (op[ALU_OR]) begin
      result = a | b;
    end else if (op[ALU_NOT]) begin
      result = ~b;
    end else if (op[ALU_LSL]) begin
      result = wide[MSB:0];
    end else if (op[ALU_LSR]) begin
      result = a >> sh;
    end else if (op[ALU_ASL]) begin
      result   = wide[MSB:0];
      carry    = wide[DATA_W];
      overflow = wide[MSB] ^ a[MSB];
    end else if (op[ALU_ASR]) begin
      result = $signed(a) >>> sh;
    end else if (op[ALU_MPY]) begin
      result = product[MSB:0];
    end
  end

endmodule

// File: rtl/cw_datapath.sv
// rtl/cw_datapath.sv - register file, transfer arbitration and memory FSM driven by one-hot control words
module cw_datapath
  import cw_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int OPC_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cw,
  input  logic              cw_valid,
  output logic              busy,
  output logic [OPC_W-1:0]  ir_opcode,
  output logic [7:0]        flags,
  cw_datapath_if.master     bus
);

  logic [ADDR_W-1:0]   pc, mar, addr_q;
  logic [DATA_W-1:0]   mbr, ir, br, acc, mr, rbuf, wdata_q;
  logic [2*DATA_W-1:0] p;
  logic                cy, ov, err;
  mem_state_e          state, state_nxt;

  logic [31:0]         w;
  logic [ALU_OPS-1:0]  op;
  logic                alu_wr, mpy_wr, op_many, err_set, mem_start;
  logic [DATA_W-1:0]   alu_a, alu_res;
  logic                alu_cy, alu_ov;
  logic [2*DATA_W-1:0] alu_prod;
  logic                unused_bits;

  // a dropped strobe executes as an all-zero word
  assign w  = (cw_valid && !busy) ? cw : 32'h0;
  assign op = w[CW_ADD +: ALU_OPS];

  assign op_many = !$onehot0(op);
  assign alu_wr  = $onehot(op) && !op[ALU_MPY];
  assign mpy_wr  = $onehot(op) && op[ALU_MPY];
  assign alu_a   = w[CW_ACC_CLR] ? '0 : acc;

  assign mem_start = w[CW_MAR2MEM] ^ w[CW_MBR2MEM];

  // clear+op is a single ACC source (ACC = 0 op BR), not a conflict
  assign err_set = (cw_valid && busy)
                 || !$onehot0({w[CW_MEM2MBR], w[CW_MR2MBR], w[CW_ACC2MBR], w[CW_PC2MBR]})
                 || (w[CW_MBR2MAR] && w[CW_PC2MAR])
                 || (w[CW_MBR2PC] && w[CW_PC_PLUS1])
                 || !$onehot0({w[CW_ACC_CLR] | alu_wr, w[CW_MPY2MR], w[CW_MBR2ACC]})
                 || op_many
                 || (w[CW_MAR2MEM] && w[CW_MBR2MEM]);

  assign unused_bits = ^{w[CW_ACC2ALU], w[CW_RSVD], w[CW_IR2CU], w[CW_BR2ALU],
                         w[CW_SEQ_MSB:CW_SEQ_LSB], ir[DATA_W-OPC_W-1:0], alu_prod[0]};

  cw_alu #(.DATA_W(DATA_W)) u_alu (
    .a        (alu_a),
    .b        (br),
    .op       (op),
    .result   (alu_res),
    .carry    (alu_cy),
    .overflow (alu_ov),
    .product  (alu_prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= '0;
      mar     <= '0;
      mbr     <= '0;
      ir      <= '0;
      br      <= '0;
      acc     <= '0;
      mr      <= '0;
      p       <= '0;
      cy      <= 1'b0;
      ov      <= 1'b0;
      err     <= 1'b0;
      rbuf    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (w[CW_MEM2MBR])      mbr <= rbuf;
      else if (w[CW_MR2MBR])  mbr <= mr;
      else if (w[CW_ACC2MBR]) mbr <= acc;
      else if (w[CW_PC2MBR])  mbr <= DATA_W'(pc);

      if (w[CW_MBR2MAR])     mar <= mbr[ADDR_W-1:0];
      else if (w[CW_PC2MAR]) mar <= pc;

      if (w[CW_MBR2PC])        pc <= mbr[ADDR_W-1:0];
      else if (w[CW_PC_PLUS1]) pc <= pc + ADDR_W'(1);

      if (w[CW_MBR2IR]) ir <= mbr;
      if (w[CW_MBR2BR]) br <= mbr;

      if (alu_wr)               acc <= alu_res;
      else if (w[CW_ACC_CLR])   acc <= '0;
      else if (w[CW_MPY2MR])    acc <= p[DATA_W-1:0];
      else if (w[CW_MBR2ACC])   acc <= mbr;

      if (w[CW_MPY2MR]) mr <= p[2*DATA_W-1:DATA_W];
      if (mpy_wr)       p  <= alu_prod;

      if (alu_wr && (op[ALU_ADD] || op[ALU_SUB] || op[ALU_ASL])) begin
        cy <= alu_cy;
        ov <= alu_ov;
      end

      err <= err | err_set;

      if (state == MEM_RD && bus.mem_ack) rbuf <= bus.mem_rdata;
      if (mem_start) begin
        addr_q  <= mar;
        wdata_q <= mbr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MEM_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MEM_IDLE: begin
        if (w[CW_MAR2MEM] && !w[CW_MBR2MEM])      state_nxt = MEM_RD;
        else if (w[CW_MBR2MEM] && !w[CW_MAR2MEM]) state_nxt = MEM_WR;
      end
      MEM_RD, MEM_WR: if (bus.mem_ack) state_nxt = MEM_IDLE;
      default: state_nxt = MEM_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state != MEM_IDLE);
    bus.mem_req   = (state != MEM_IDLE);
    bus.mem_we    = (state == MEM_WR);
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
  end

  always_comb begin
    flags            = '0;
    flags[FLG_NEG]   = acc[DATA_W-1];
    flags[FLG_ZERO]  = (acc == '0);
    flags[FLG_CARRY] = cy;
    flags[FLG_OVF]   = ov;
    flags[FLG_ERR]   = err;
  end

  assign ir_opcode = ir[DATA_W-1 -: OPC_W];

endmodule

// File: tb/tb_cw_datapath.sv
// tb/tb_cw_datapath.sv - directed tests with a per-cycle behavioural model of the datapath
module tb_cw_datapath;
  import cw_pkg::*;

  logic        clk, rst;
  logic [31:0] cw;
  logic        cw_valid;
  logic        busy;
  logic [7:0]  ir_opcode;
  logic [7:0]  flags;
  int          total = 0;
  int          bad = 0;

  cw_datapath_if #(.DATA_W(16), .ADDR_W(8)) bus ();

  cw_datapath dut (
    .clk       (clk),
    .rst       (rst),
    .cw        (cw),
    .cw_valid  (cw_valid),
    .busy      (busy),
    .ir_opcode (ir_opcode),
    .flags     (flags),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pc, mar, maddr;
    logic [15:0] mbr, ir, br, acc, mr, rbuf, mwd;
    logic [31:0] p;
    logic        cy, ov, err;
    int          st;  // 0 idle, 1 read outstanding, 2 write outstanding
  } mstate_t;

  mstate_t m, mn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bit_of(input int i);
    logic [31:0] one = 32'h1;
    return one << i;
  endfunction

  task automatic model_reset();
    m = '{default: 0};
    mn = m;
  endtask

  task automatic model_next(input logic [31:0] c, input logic v, input logic ack, input logic [15:0] rd);
    logic [15:0] a, r;
    logic        ncy, nov, aluw;
    int          nops, ia, ib, s, sh;
    longint      prod;
    mn = m;
    if (m.st != 0) begin
      if (v) mn.err = 1'b1;
      if (ack) begin
        if (m.st == 1) mn.rbuf = rd;
        mn.st = 0;
      end
      return;
    end
    if (!v) return;
    nops = $countones(c[31:22]);
    a  = c[CW_ACC_CLR] ? 16'h0 : m.acc;
    ia = int'($signed(a));
    ib = int'($signed(m.br));
    sh = int'(m.br[3:0]);
    r = 16'h0; ncy = m.cy; nov = m.ov;
    aluw = (nops == 1) && !c[CW_MPY];
    if (nops > 1) mn.err = 1'b1;
    if (nops == 1) begin
      if (c[CW_ADD]) begin
        s = ia + ib; r = s[15:0];
        ncy = (int'(a) + int'(m.br)) > 65535;
        nov = (s > 32767) || (s < -32768);
      end
      if (c[CW_SUB]) begin
        s = ia - ib; r = s[15:0];
        ncy = (a >= m.br);
        nov = (s > 32767) || (s < -32768);
      end
      if (c[CW_AND]) r = a & m.br;
      if (c[CW_OR])  r = a | m.br;
      if (c[CW_NOT]) r = ~m.br;
      if (c[CW_LSL]) begin s = int'(a) << sh; r = s[15:0]; end
      if (c[CW_LSR]) begin s = int'(a) >> sh; r = s[15:0]; end
      if (c[CW_ASL]) begin
        s = int'(a) << sh; r = s[15:0];
        nov = (r[15] != a[15]);
        ncy = (sh == 0) ? 1'b0 : (((int'(a) >> (16 - sh)) & 1) != 0);
      end
      if (c[CW_ASR]) begin s = ia >>> sh; r = s[15:0]; end
      if (c[CW_MPY]) begin prod = longint'(ia) * longint'(ib); mn.p = prod[31:0]; end
    end
    if (aluw) begin
      mn.acc = r; mn.cy = ncy; mn.ov = nov;
    end else if (c[CW_ACC_CLR]) mn.acc = 16'h0;
    else if (c[CW_MPY2MR])     mn.acc = m.p[15:0];
    else if (c[CW_MBR2ACC])    mn.acc = m.mbr;
    if (int'(c[CW_ACC_CLR] | aluw) + int'(c[CW_MPY2MR]) + int'(c[CW_MBR2ACC]) > 1) mn.err = 1'b1;
    if (c[CW_MPY2MR]) mn.mr = m.p[31:16];

    if (c[CW_MEM2MBR])      mn.mbr = m.rbuf;
    else if (c[CW_MR2MBR])  mn.mbr = m.mr;
    else if (c[CW_ACC2MBR]) mn.mbr = m.acc;
    else if (c[CW_PC2MBR])  mn.mbr = {8'h00, m.pc};
    if ($countones({c[CW_MEM2MBR], c[CW_MR2MBR], c[CW_ACC2MBR], c[CW_PC2MBR]}) > 1) mn.err = 1'b1;

    if (c[CW_MBR2MAR])     mn.mar = m.mbr[7:0];
    else if (c[CW_PC2MAR]) mn.mar = m.pc;
    if (c[CW_MBR2MAR] && c[CW_PC2MAR]) mn.err = 1'b1;

    if (c[CW_MBR2PC])        mn.pc = m.mbr[7:0];
    else if (c[CW_PC_PLUS1]) mn.pc = 8'((int'(m.pc) + 1) % 256);
    if (c[CW_MBR2PC] && c[CW_PC_PLUS1]) mn.err = 1'b1;

    if (c[CW_MBR2IR]) mn.ir = m.mbr;
    if (c[CW_MBR2BR]) mn.br = m.mbr;

    if (c[CW_MAR2MEM] && c[CW_MBR2MEM]) mn.err = 1'b1;
    else if (c[CW_MAR2MEM]) begin mn.st = 1; mn.maddr = m.mar; end
    else if (c[CW_MBR2MEM]) begin mn.st = 2; mn.maddr = m.mar; mn.mwd = m.mbr; end
  endtask

  // outputs compared with the model on every falling edge
  always @(negedge clk) begin
    chk("pc", 32'(dut.pc), 32'(m.pc));
    chk("mar", 32'(dut.mar), 32'(m.mar));
    chk("mbr", 32'(dut.mbr), 32'(m.mbr));
    chk("ir", 32'(dut.ir), 32'(m.ir));
    chk("br", 32'(dut.br), 32'(m.br));
    chk("acc", 32'(dut.acc), 32'(m.acc));
    chk("mr", 32'(dut.mr), 32'(m.mr));
    chk("ir_opcode", 32'(ir_opcode), 32'(m.ir[15:8]));
    chk("flags", 32'(flags), 32'({3'b000, m.err, m.ov, m.cy, m.acc == 16'h0, m.acc[15]}));
    chk("busy", 32'(busy), 32'(m.st != 0));
    chk("mem_req", 32'(bus.mem_req), 32'(m.st != 0));
    chk("mem_we", 32'(bus.mem_we), 32'(m.st == 2));
    if (m.st != 0) chk("mem_addr", 32'(bus.mem_addr), 32'(m.maddr));
    if (m.st == 2) chk("mem_wdata", 32'(bus.mem_wdata), 32'(m.mwd));
  end

  task automatic cyc(input logic [31:0] c, input logic v, input logic ack, input logic [15:0] rd);
    cw = c; cw_valid = v; bus.mem_ack = ack; bus.mem_rdata = rd;
    model_next(c, v, ack, rd);
    @(posedge clk);
    #1 m = mn;
    @(negedge clk);
    cw = 32'h0; cw_valid = 1'b0; bus.mem_ack = 1'b0;
  endtask

  task automatic step(input logic [31:0] c);
    cyc(c, 1'b1, 1'b0, 16'h0);
  endtask

  task automatic idle();
    cyc(32'h0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic ackc(input logic [15:0] d);
    cyc(32'h0, 1'b0, 1'b1, d);
  endtask

  task automatic load_mbr(input logic [15:0] d);
    step(bit_of(CW_MAR2MEM));
    idle();
    ackc(d);
    step(bit_of(CW_MEM2MBR));
  endtask

  typedef struct {
    logic [15:0] a, b;
    int          opbit;
    logic [15:0] exp;
  } op_vec_t;

  op_vec_t vecs[9];
  int      nbusy;

  initial begin
    vecs[0] = '{16'hFFFA, 16'h0003, CW_SUB, 16'hFFF7};
    vecs[1] = '{16'h4000, 16'h0001, CW_ASL, 16'h8000};
    vecs[2] = '{16'h8000, 16'h0004, CW_ASR, 16'hF800};
    vecs[3] = '{16'h00F0, 16'h0F0F, CW_AND, 16'h0000};
    vecs[4] = '{16'h00F0, 16'h0F0F, CW_OR,  16'h0FFF};
    vecs[5] = '{16'h0000, 16'h00FF, CW_NOT, 16'hFF00};
    vecs[6] = '{16'h0001, 16'h000F, CW_LSL, 16'h8000};
    vecs[7] = '{16'h8000, 16'h000F, CW_LSR, 16'h0001};
    vecs[8] = '{16'h8000, 16'h8000, CW_ADD, 16'h0000};

    rst = 1'b1; cw = 32'h0; cw_valid = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 16'h0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset flags", 32'(flags), 32'h02);
    chk("reset busy", 32'(busy), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // fetch of instruction 0x0305 from address 0
    step(bit_of(CW_PC2MAR));
    step(bit_of(CW_MAR2MEM));
    nbusy = int'(busy);
    idle();
    nbusy += int'(busy);
    ackc(16'h0305);
    nbusy += int'(busy);
    chk("fetch busy cycles", 32'(nbusy), 32'd2);
    step(bit_of(CW_MEM2MBR));
    step(bit_of(CW_MBR2IR));
    chk("fetch opcode", 32'(ir_opcode), 32'h03);
    chk("fetch mbr", 32'(dut.mbr), 32'h0305);

    // 0x7FFF + 1 overflows into the sign bit
    load_mbr(16'h7FFF); step(bit_of(CW_MBR2ACC));
    load_mbr(16'h0001); step(bit_of(CW_MBR2BR));
    step(bit_of(CW_ADD));
    chk("add acc", 32'(dut.acc), 32'h8000);
    chk("add flags", 32'(flags), 32'h09);

    load_mbr(16'h1234); step(bit_of(CW_MBR2ACC));
    load_mbr(16'h00AA); step(bit_of(CW_MBR2BR));
    step(bit_of(CW_ACC_CLR) | bit_of(CW_ADD));
    chk("load acc", 32'(dut.acc), 32'h00AA);
    chk("load err", 32'(flags[FLG_ERR]), 32'h0);

    load_mbr(16'hFFFE); step(bit_of(CW_MBR2ACC));
    load_mbr(16'h0003); step(bit_of(CW_MBR2BR));
    step(bit_of(CW_MPY));
    step(bit_of(CW_MPY2MR));
    chk("mpy mr", 32'(dut.mr), 32'hFFFF);
    chk("mpy acc", 32'(dut.acc), 32'hFFFA);
    step(bit_of(CW_MR2MBR));

    foreach (vecs[i]) begin
      load_mbr(vecs[i].a); step(bit_of(CW_MBR2ACC));
      load_mbr(vecs[i].b); step(bit_of(CW_MBR2BR));
      step(bit_of(vecs[i].opbit));
      chk($sformatf("op%0d acc", i), 32'(dut.acc), 32'(vecs[i].exp));
    end
    chk("add carry+ovf", 32'(flags[3:2]), 32'h3);

    // PC wrap, then simultaneous MAR load and PC increment
    load_mbr(16'h00FF); step(bit_of(CW_MBR2PC));
    step(bit_of(CW_PC_PLUS1));
    chk("pc wrap", 32'(dut.pc), 32'h00);
    step(bit_of(CW_MBR2MAR) | bit_of(CW_PC_PLUS1));
    chk("pc+1 with mar", 32'(dut.pc), 32'h01);
    chk("mar from mbr", 32'(dut.mar), 32'hFF);

    // store, with a strobe arriving while the write is outstanding
    load_mbr(16'h0010); step(bit_of(CW_MBR2MAR));
    load_mbr(16'hBEEF);
    step(bit_of(CW_MBR2MEM));
    step(bit_of(CW_PC_PLUS1));
    chk("store we", 32'(bus.mem_we), 32'h1);
    chk("store addr", 32'(bus.mem_addr), 32'h10);
    chk("store wdata", 32'(bus.mem_wdata), 32'hBEEF);
    chk("store pc held", 32'(dut.pc), 32'h01);
    chk("store err", 32'(flags[FLG_ERR]), 32'h1);
    ackc(16'h0);

    // reset while a read is outstanding
    step(bit_of(CW_MAR2MEM));
    chk("rd req", 32'(bus.mem_req), 32'h1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("rst req", 32'(bus.mem_req), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst acc", 32'(dut.acc), 32'h0);
    chk("rst flags", 32'(flags), 32'h02);
    @(negedge clk);
    rst = 1'b0;
    ackc(16'h5A5A);
    step(bit_of(CW_MEM2MBR));
    chk("late ack", 32'(dut.mbr), 32'h0);

    // conflicts
    load_mbr(16'h0042);
    step(bit_of(CW_PC2MAR) | bit_of(CW_MBR2MAR));
    chk("mar conflict", 32'(dut.mar), 32'h42);
    chk("conflict err", 32'(flags), 32'h12);
    step(bit_of(CW_MAR2MEM) | bit_of(CW_MBR2MEM));
    chk("dual req", 32'(busy), 32'h0);
    step(bit_of(CW_MBR2ACC));
    step(bit_of(CW_ADD) | bit_of(CW_SUB));
    chk("multi op", 32'(dut.acc), 32'h42);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
